completion_arbiter: RTL and testbench

Shares the single ROB completion (wakeup) port among the three functional units and the load/store queue.
- Each of the 4 sources has a small in-order FIFO for its completions.
- A round-robin arbiter drains one completion per cycle to the ROB: rob_index, physical rd tag, value.
- Sits between the FU/LSQ wakeup outputs and the ReorderBuffer wakeup inputs. The RS tag broadcast stays direct from the FUs and is not routed through this block.

---
 rtl/completion_arbiter.sv | 154 +++++++++++++++
 tb/tb_completion_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/completion_arbiter.sv
// completion_arbiter: per-source in-order completion FIFOs drained round-robin onto the single ROB wakeup port.
// Optional per-source stall counters (port stall_cnt) are enabled by defining COMPLETION_ARB_STATS_EN.

module completion_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int ROB_W      = 6,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]  src_rob_index,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_value,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      rob_ready,
  output logic                      rob_wb_valid,
  output logic [1:0]                rob_wb_src,
  output logic [ROB_W-1:0]          rob_wb_rob_index,
  output logic [TAG_W-1:0]          rob_wb_tag,
  output logic [DATA_W-1:0]         rob_wb_value
`ifdef COMPLETION_ARB_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]     stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int ENT_W = ROB_W + TAG_W + DATA_W;

  logic [ENT_W-1:0] mem_r    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_r [NUM_SRC];
  logic [CNT_W-1:0] count_r  [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr_r;

  logic [NUM_SRC-1:0] enq_s;
  logic [NUM_SRC-1:0] deq_s;
  logic [SRC_W-1:0]   win_s;
  logic               any_s;
  logic               xfer_s;
  logic [ENT_W-1:0]   head_s;

  // Per-source ready from the registered occupancy and enqueue qualification.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count_r[i] < CNT_W'(FIFO_DEPTH));
      enq_s[i]     = src_valid[i] && src_ready[i] && !flush;
    end
  end

  // Round-robin scan over non-empty FIFOs starting at rr_ptr_r.
  always_comb begin
    any_s = 1'b0;
    win_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = (int'(rr_ptr_r) + k) % NUM_SRC;
      if (!any_s && (count_r[idx] != '0)) begin
        any_s = 1'b1;
        win_s = SRC_W'(idx);
      end else begin
        any_s = any_s;
      end
    end
  end

  // Present the winner's head entry; everything reads zero when nothing is offered.
  always_comb begin
    head_s       = mem_r[win_s][rd_ptr_r[win_s]];
    rob_wb_valid = any_s && !flush;
    xfer_s       = rob_wb_valid && rob_ready;
    if (rob_wb_valid) begin
      rob_wb_src                                     = 2'(win_s);
      {rob_wb_rob_index, rob_wb_tag, rob_wb_value}   = head_s;
    end else begin
      rob_wb_src       = 2'b00;
      rob_wb_rob_index = '0;
      rob_wb_tag       = '0;
      rob_wb_value     = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      deq_s[i] = xfer_s && (win_s == SRC_W'(i));
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (enq_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= {src_rob_index[i*ROB_W +: ROB_W],
                                  src_tag[i*TAG_W +: TAG_W],
                                  src_value[i*DATA_W +: DATA_W]};
      end
    end
  end

  // Occupancy, pointers and round-robin state; flush empties FIFOs but keeps rr_ptr_r.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_r <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        count_r[i]  <= '0;
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_r[i]  <= '0;
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (enq_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
        if (deq_s[i]) rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
        count_r[i] <= count_r[i] + CNT_W'(enq_s[i]) - CNT_W'(deq_s[i]);
      end
      if (xfer_s) begin
        rr_ptr_r <= (win_s == SRC_W'(NUM_SRC - 1)) ? '0 : win_s + SRC_W'(1);
      end
    end
  end

`ifdef COMPLETION_ARB_STATS_EN
  logic [15:0] stall_r [NUM_SRC];

  // Saturating count of cycles each source was held off while full; survives flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) stall_r[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && !src_ready[i] && (stall_r[i] != 16'hFFFF)) begin
          stall_r[i] <= stall_r[i] + 16'd1;
        end
      end
    end
  end

  // Pack the counters onto the output bus.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      stall_cnt[i*16 +: 16] = stall_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_completion_arbiter.sv
// Self-checking bench for completion_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.

module tb_completion_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   src_valid;
  logic [23:0]  src_rob_index;
  logic [23:0]  src_tag;
  logic [127:0] src_value;
  logic [3:0]   src_ready;
  logic         rob_ready;
  logic         rob_wb_valid;
  logic [1:0]   rob_wb_src;
  logic [5:0]   rob_wb_rob_index;
  logic [5:0]   rob_wb_tag;
  logic [31:0]  rob_wb_value;
`ifdef COMPLETION_ARB_STATS_EN
  logic [63:0]  stall_cnt;
  int           stall_m [4];
`endif

  always #5 clk = ~clk;

  completion_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .src_valid        (src_valid),
    .src_rob_index    (src_rob_index),
    .src_tag          (src_tag),
    .src_value        (src_value),
    .src_ready        (src_ready),
    .rob_ready        (rob_ready),
    .rob_wb_valid     (rob_wb_valid),
    .rob_wb_src       (rob_wb_src),
    .rob_wb_rob_index (rob_wb_rob_index),
    .rob_wb_tag       (rob_wb_tag),
    .rob_wb_value     (rob_wb_value)
`ifdef COMPLETION_ARB_STATS_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [5:0]  rob;
    logic [5:0]  tag;
    logic [31:0] val;
  } ent_t;

  ent_t q [4][$];
  int   rr;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   check_en = 1'b0;

  logic       obs_valid;
  logic [1:0] obs_src;
  logic [5:0] obs_idx;
  logic [5:0] obs_tag;
  logic [31:0] obs_val;
  logic [3:0] obs_ready;
  int         got_src [$];
  int         got_idx [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (rr + k) % 4;
      if (q[s].size() != 0) return s;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input logic [5:0] r, input logic [5:0] t, input logic [31:0] v);
    src_rob_index[i*6 +: 6] = r;
    src_tag[i*6 +: 6]       = t;
    src_value[i*32 +: 32]   = v;
  endtask

  // One clock: compare DUT against the model, then advance the model at the edge.
  task automatic step();
    int         w;
    logic       ev;
    logic [3:0] er;
    ent_t       h;
    #1;
    w  = model_winner();
    ev = (w >= 0) && !flush;
    for (int i = 0; i < 4; i++) er[i] = (q[i].size() < 2);
    obs_valid = rob_wb_valid; obs_src = rob_wb_src; obs_idx = rob_wb_rob_index;
    obs_tag = rob_wb_tag; obs_val = rob_wb_value; obs_ready = src_ready;
    if (check_en) begin
      chk("src_ready", src_ready, er);
      chk("wb_valid", rob_wb_valid, ev);
      if (ev) begin
        h = q[w][0];
        chk("wb_src", rob_wb_src, w);
        chk("wb_rob_index", rob_wb_rob_index, h.rob);
        chk("wb_tag", rob_wb_tag, h.tag);
        chk("wb_value", rob_wb_value, h.val);
      end else begin
        chk("wb_zero", {rob_wb_src, rob_wb_rob_index, rob_wb_tag, rob_wb_value}, 64'd0);
      end
`ifdef COMPLETION_ARB_STATS_EN
      for (int i = 0; i < 4; i++) chk("stall_cnt", stall_cnt[i*16 +: 16], stall_m[i]);
`endif
    end
    if (rob_wb_valid && rob_ready) begin
      got_src.push_back(int'(rob_wb_src));
      got_idx.push_back(int'(rob_wb_rob_index));
    end
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      rr = 0;
`ifdef COMPLETION_ARB_STATS_EN
      for (int i = 0; i < 4; i++) stall_m[i] = 0;
`endif
    end else begin
`ifdef COMPLETION_ARB_STATS_EN
      for (int i = 0; i < 4; i++)
        if (src_valid[i] && !er[i] && stall_m[i] < 65535) stall_m[i]++;
`endif
      if (flush) begin
        for (int i = 0; i < 4; i++) q[i].delete();
      end else begin
        if (ev && rob_ready) begin
          h  = q[w].pop_front();
          rr = (w + 1) % 4;
        end
        for (int i = 0; i < 4; i++)
          if (src_valid[i] && er[i])
            q[i].push_back({src_rob_index[i*6 +: 6], src_tag[i*6 +: 6], src_value[i*32 +: 32]});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; rob_ready = 1'b0; src_valid = 4'b1111;
    src_rob_index = 24'hABCDEF; src_tag = 24'h123456; src_value = {4{32'hCAFEF00D}};
    @(negedge clk);

    // Test 1: reset with all sources requesting.
    step();
    check_en = 1'b1;
    step();
    reset = 1'b1; src_valid = 4'b0000;
    step();
    chk("t1_valid", obs_valid, 1'b0);
    chk("t1_ready", obs_ready, 4'b1111);
    chk("t1_data", {obs_src, obs_idx, obs_tag, obs_val}, 64'd0);

    // Test 2: single FU2 completion.
    rob_ready = 1'b1; src_valid = 4'b0010;
    set_src(1, 6'd5, 6'd33, 32'hDEADBEEF);
    got_src.delete(); got_idx.delete();
    step();
    chk("t2_no_bypass", obs_valid, 1'b0);
    src_valid = 4'b0000;
    step();
    chk("t2_valid", obs_valid, 1'b1);
    chk("t2_src", obs_src, 2'd1);
    chk("t2_idx", obs_idx, 6'd5);
    chk("t2_tag", obs_tag, 6'd33);
    chk("t2_val", obs_val, 32'hDEADBEEF);
    step();
    chk("t2_empty", obs_valid, 1'b0);

    // Bring rr back to 0 via one LSQ completion.
    src_valid = 4'b1000; set_src(3, 6'd1, 6'd1, 32'd1);
    step();
    src_valid = 4'b0000;
    step();
    step();

    // Test 3: all four sources at once, rr at 0.
    for (int i = 0; i < 4; i++) set_src(i, 6'(10 + i), 6'(40 + i), 32'(i));
    src_valid = 4'b1111;
    got_src.delete(); got_idx.delete();
    step();
    src_valid = 4'b0000;
    for (int k = 0; k < 5; k++) step();
    chk("t3_count", got_src.size(), 4);
    for (int k = 0; k < got_src.size() && k < 4; k++) begin
      chk("t3_src", got_src[k], k);
      chk("t3_idx", got_idx[k], 10 + k);
    end
    chk("t3_empty", obs_valid, 1'b0);

    // Test 4: LSQ back-pressure with the ROB stalled.
    rob_ready = 1'b0; src_valid = 4'b1000;
    got_src.delete(); got_idx.delete();
    set_src(3, 6'd20, 6'd2, 32'h20); step();
    set_src(3, 6'd21, 6'd3, 32'h21); step();
    set_src(3, 6'd22, 6'd4, 32'h22); step();
    chk("t4_full", obs_ready[3], 1'b0);
    step(); step();
    rob_ready = 1'b1;
    step(); step();
    src_valid = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    chk("t4_count", got_idx.size(), 3);
    for (int k = 0; k < got_idx.size() && k < 3; k++) begin
      chk("t4_src", got_src[k], 3);
      chk("t4_idx", got_idx[k], 20 + k);
    end
`ifdef COMPLETION_ARB_STATS_EN
    chk("t4_stall", stall_cnt[63:48], 16'd4);
`endif

    // Test 5: flush discards buffered and same-cycle entries.
    rob_ready = 1'b0; src_valid = 4'b0101;
    set_src(0, 6'd30, 6'd5, 32'h30); set_src(2, 6'd31, 6'd6, 32'h31);
    step(); step();
    flush = 1'b1; src_valid = 4'b0010;
    step();
    chk("t5_flush_valid", obs_valid, 1'b0);
    flush = 1'b0; src_valid = 4'b0000;
    step();
    chk("t5_after_valid", obs_valid, 1'b0);
    chk("t5_ready", obs_ready, 4'b1111);
    rob_ready = 1'b1;
    step();
    chk("t5_nothing_left", obs_valid, 1'b0);

    // Test 6: sources 0 and 3 always valid alternate.
    src_valid = 4'b1001;
    got_src.delete(); got_idx.delete();
    for (int k = 0; k < 12; k++) begin
      set_src(0, 6'($urandom), 6'($urandom), $urandom);
      set_src(3, 6'($urandom), 6'($urandom), $urandom);
      step();
    end
    chk("t6_count", got_src.size() >= 10, 1'b1);
    for (int k = 1; k < got_src.size(); k++) begin
      chk("t6_alternate", got_src[k] != got_src[k-1], 1'b1);
      chk("t6_members", (got_src[k] == 0) || (got_src[k] == 3), 1'b1);
    end
    src_valid = 4'b0000;
    step(); step(); step();

    // Randomized phase against the model.
    for (int c = 0; c < 800; c++) begin
      src_valid     = 4'($urandom);
      src_rob_index = 24'($urandom);
      src_tag       = 24'($urandom);
      src_value     = {$urandom, $urandom, $urandom, $urandom};
      rob_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1; flush = 1'b0; src_valid = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
